// File: rtl/uart_rx_sampler_pkg.sv
// rtl/uart_rx_sampler_pkg.sv - shared uart constants and prescale legality helper
package uart_rx_sampler_pkg;

  localparam int DEFAULT_PRESCALE_W = 6;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // True only for the oversampling ratios the receiver supports.
  function automatic logic is_legal_prescale(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - handshake between the RX FSM and the oversampling front end
interface uart_rx_sampler_if
  import uart_rx_sampler_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) ();

  logic                  edge_bit_en;
  logic                  dat_samp_en;
  logic                  S_DATA;
  logic [PRESCALE_W-1:0] edge_count;
  logic [3:0]            bit_count;
  logic                  sampled_bit;
  logic                  sample_valid;

  // RX FSM side
  modport master (
    output edge_bit_en, dat_samp_en,
    input  S_DATA, edge_count, bit_count, sampled_bit, sample_valid
  );

  // Sampler side
  modport slave (
    input  edge_bit_en, dat_samp_en,
    output S_DATA, edge_count, bit_count, sampled_bit, sample_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - prescale latch plus oversampling edge and bit counters
module uart_rx_edge_bit_counter
  import uart_rx_sampler_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  edge_bit_en,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [3:0]            bit_count,
  output logic                  cfg_err,
  output logic [PRESCALE_W-1:0] p_eff
);

  // Track Prescale while idle and freeze it for the whole frame; illegal ratios fall back to 8.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_eff   <= PRESCALE_W'(PRESCALE_8);
      cfg_err <= 1'b0;
    end else if (!edge_bit_en) begin
      if (is_legal_prescale(32'(Prescale))) begin
        p_eff   <= Prescale;
        cfg_err <= 1'b0;
      end else begin
        p_eff   <= PRESCALE_W'(PRESCALE_8);
        cfg_err <= 1'b1;
      end
    end
  end

  // Count oversampling edges within a bit and bits within a frame; bit index saturates at 15.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!edge_bit_en) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == p_eff - PRESCALE_W'(1)) begin
      edge_count <= '0;
      if (bit_count != 4'd15) begin
        bit_count <= bit_count + 4'd1;
      end
    end else begin
      edge_count <= edge_count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - RX line synchronizer with 3-point majority-vote bit sampler
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  cfg_err,
  uart_rx_sampler_if.slave      fsm
);

  logic                  sync_q;
  logic                  s_data_q;
  logic [PRESCALE_W-1:0] edge_count_q;
  logic [3:0]            bit_count_q;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] mid;
  logic [2:0]            cap_q;
  logic [2:0]            seen_q;
  logic                  sampled_q;
  logic                  valid_q;

  assign mid = p_eff >> 1;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q   <= 1'b1;
      s_data_q <= 1'b1;
    end else begin
      sync_q   <= RX_IN;
      s_data_q <= sync_q;
    end
  end

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_edge_bit_counter (
    .CLK         (CLK),
    .RST         (RST),
    .edge_bit_en (fsm.edge_bit_en),
    .Prescale    (Prescale),
    .edge_count  (edge_count_q),
    .bit_count   (bit_count_q),
    .cfg_err     (cfg_err),
    .p_eff       (p_eff)
  );

  // Capture around the midpoint and vote; seen_q chains so a bit whose enable dropped
  // at any capture point never produces a strobe from stale captures.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_q     <= 3'b111;
      seen_q    <= 3'b000;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (edge_count_q == mid - PRESCALE_W'(1)) begin
        seen_q[0] <= fsm.dat_samp_en;
        if (fsm.dat_samp_en) cap_q[0] <= s_data_q;
      end
      if (edge_count_q == mid) begin
        seen_q[1] <= fsm.dat_samp_en & seen_q[0];
        if (fsm.dat_samp_en) cap_q[1] <= s_data_q;
      end
      if (edge_count_q == mid + PRESCALE_W'(1)) begin
        seen_q[2] <= fsm.dat_samp_en & seen_q[1];
        if (fsm.dat_samp_en) cap_q[2] <= s_data_q;
      end
      if ((edge_count_q == mid + PRESCALE_W'(2)) && fsm.dat_samp_en && seen_q[2]) begin
        sampled_q <= (cap_q[0] & cap_q[1]) | (cap_q[0] & cap_q[2]) | (cap_q[1] & cap_q[2]);
        valid_q   <= 1'b1;
      end
    end
  end

  assign fsm.S_DATA       = s_data_q;
  assign fsm.edge_count   = edge_count_q;
  assign fsm.bit_count    = bit_count_q;
  assign fsm.sampled_bit  = sampled_q;
  assign fsm.sample_valid = valid_q;

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, meaning the width of the prescale and edge counters.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RX_IN  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port Prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have port edge_bit_en  input  1  counter enable from the RX FSM.
REQ-007 SHALL have port dat_samp_en  input  1  sampling enable from the RX FSM.
REQ-008 SHALL have port S_DATA  output  1  synchronized RX_IN, fed to the FSM.
REQ-009 SHALL have port edge_count  output  PRESCALE_W  oversampling edge index within the current bit.
REQ-010 SHALL have port bit_count  output  4  bit index within the frame.
REQ-011 SHALL have port sampled_bit  output  1  majority-voted bit value.
REQ-012 SHALL have port sample_valid  output  1  one-cycle strobe; asserted when sampled_bit is updated.
REQ-013 SHALL have port cfg_err  output  1  latched Prescale value is illegal.

Function
REQ-014 RX_IN SHALL pass through a 2-flop synchronizer; S_DATA = second flop; latency 2 cycles.
REQ-015 Latched prescale P SHALL load from Prescale on every cycle with edge_bit_en=0.
REQ-016 P SHALL hold while edge_bit_en=1; a Prescale change mid-frame takes effect on the next frame.
REQ-017 If the latched value is not in {8,16,32}: cfg_err=1 and P_eff=8; otherwise cfg_err=0 and P_eff=P.
REQ-018 With edge_bit_en=0: edge_count SHALL be 0 and bit_count SHALL be 0 on the next clock.
REQ-019 With edge_bit_en=1 and edge_count=P_eff-1: edge_count SHALL become 0 and bit_count SHALL increment.
REQ-020 With edge_bit_en=1 and edge_count below P_eff-1: edge_count SHALL increment; bit_count holds.
REQ-021 bit_count SHALL saturate at 15 and never wrap to 0 while enabled.
REQ-022 Midpoint M SHALL equal P_eff/2, i.e. 4, 8 or 16.
REQ-023 With dat_samp_en=1, S_DATA SHALL be captured at edge_count M-1, M and M+1, one register per point.
REQ-024 At edge_count=M+2 with dat_samp_en=1: sampled_bit SHALL take the majority (2-of-3) of the captures and sample_valid SHALL pulse for exactly 1 cycle.
REQ-025 With dat_samp_en=0: no capture occurs, sampled_bit holds and sample_valid=0.
REQ-026 If dat_samp_en falls between capture points: no sample_valid for that bit, and stale captures are overwritten in the next bit.
REQ-027 Simultaneous edge_bit_en fall and edge_count=M+2: sample_valid SHALL still pulse, because it is driven by the current-cycle edge_count.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 RST low SHALL asynchronously set: synchronizer flops=1, S_DATA=1, edge_count=0, bit_count=0.
REQ-030 RST low SHALL also asynchronously set: captures=1, sampled_bit=1, sample_valid=0, P=8, cfg_err=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release the counters restart from 0 only when edge_bit_en=1.
REQ-032 Reset release SHALL be synchronous to CLK, handled by the external reset synchronizer.

Structure
REQ-033 Legal prescale constants (8, 16, 32) and the default width SHALL live in the shared uart package.
REQ-034 The edge and bit counters SHALL be a sub-module named uart_rx_edge_bit_counter; sampling and majority logic stays in the top.

Verification
REQ-035 Prescale=8, edge_bit_en=1 for 24 cycles -> edge_count 0..7 repeating; bit_count 0,1,2; then 3 after wrap.
REQ-036 Prescale=16, dat_samp_en=1, S_DATA=0 at edges 7 and 9 and 1 at edge 8 -> sampled_bit=0 and sample_valid pulse at edge_count=10.
REQ-037 Prescale=8, a 1-cycle RX_IN glitch at the midpoint -> majority rejects the glitch and sampled_bit equals the line level.
REQ-038 Prescale=12 latched -> cfg_err=1, edge_count wraps at 7.
REQ-039 Prescale changed from 8 to 32 while edge_bit_en=1 -> wrap stays at 7 until edge_bit_en drops, then wraps at 31.
REQ-040 RST pulsed low at bit_count=5 -> all outputs at reset values immediately, with no sample_valid afterward.
